// File: rtl/add_pipe.sv
// Pipelined unsigned add/sub with a carry chain sliced across STAGES registers and a valid/ready stall.
// Optional unsigned saturation is compiled in with the ADD_PIPE_SAT_EN macro.
module add_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             sat
);

  localparam int SW = (WIDTH + STAGES - 1) / STAGES;

  // Adds bits [lo, lo+SW) of a and b into a; bits outside the slice pass through.
  // Returns {carry, a-with-slice-summed}. A slice past WIDTH just forwards the carry.
  function automatic logic [WIDTH:0] add_slice(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input int lo);
    logic [WIDTH-1:0] r;
    logic             c;
    r = a;
    c = cin;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo && i < lo + SW) begin
        r[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return {c, r};
  endfunction

  logic             vld_q, cout_q, sat_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] fin_x, fin_y;
  logic             fin_c, fin_v;
`ifdef ADD_PIPE_SAT_EN
  logic             fin_sub;
`endif

  assign in_ready  = out_ready || !vld_q;
  assign out_valid = vld_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign sat       = sat_q;

  // Subtract is in0 + ~in1 + 1: invert once here, inject the +1 as carry-in.
  assign y_in = sub ? ~in1 : in1;

  generate
    if (STAGES == 1) begin : g_one
      assign fin_x = in0;
      assign fin_y = y_in;
      assign fin_c = sub;
      assign fin_v = in_valid;
`ifdef ADD_PIPE_SAT_EN
      assign fin_sub = sub;
`endif
    end else begin : g_mid
      logic [STAGES-1:1][WIDTH:0]   xc_q, xc_d;
      logic [STAGES-1:1][WIDTH-1:0] y_q;
      logic [STAGES-1:1]            vld_pipe_q;
`ifdef ADD_PIPE_SAT_EN
      logic [STAGES-1:1]            sub_q;
      assign fin_sub = sub_q[STAGES-1];
`endif

      always_comb begin
        xc_d    = '0;
        xc_d[1] = add_slice(in0, y_in, sub, 0);
        for (int k = 2; k < STAGES; k++)
          xc_d[k] = add_slice(xc_q[k-1][WIDTH-1:0], y_q[k-1], xc_q[k-1][WIDTH], (k-1)*SW);
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          vld_pipe_q <= '0;
        end else if (in_ready) begin
          xc_q          <= xc_d;
          y_q[1]        <= y_in;
          vld_pipe_q[1] <= in_valid;
`ifdef ADD_PIPE_SAT_EN
          sub_q[1]      <= sub;
`endif
          for (int k = 2; k < STAGES; k++) begin
            y_q[k]        <= y_q[k-1];
            vld_pipe_q[k] <= vld_pipe_q[k-1];
`ifdef ADD_PIPE_SAT_EN
            sub_q[k]      <= sub_q[k-1];
`endif
          end
        end
      end

      assign fin_x = xc_q[STAGES-1][WIDTH-1:0];
      assign fin_c = xc_q[STAGES-1][WIDTH];
      assign fin_y = y_q[STAGES-1];
      assign fin_v = vld_pipe_q[STAGES-1];
    end
  endgenerate

  logic [WIDTH:0]   fin_sum;
  logic [WIDTH-1:0] out_d;
  logic             sat_d;

  always_comb begin
    fin_sum = add_slice(fin_x, fin_y, fin_c, (STAGES-1)*SW);
    out_d   = fin_sum[WIDTH-1:0];
`ifdef ADD_PIPE_SAT_EN
    // Add overflows on carry; sub underflows on missing carry (borrow).
    sat_d = fin_sub ? ~fin_sum[WIDTH] : fin_sum[WIDTH];
    if (sat_d) out_d = fin_sub ? '0 : '1;
`else
    sat_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= 1'b0;
      out_q  <= '0;
      cout_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (in_ready) begin
      vld_q  <= fin_v;
      out_q  <= out_d;
      cout_q <= fin_sum[WIDTH];
      sat_q  <= sat_d;
    end
  end

endmodule
